// File: rtl/gray_disp_pkg.sv
// Shared definitions for the binary-to-Gray board display.
//   disp_state_e : which digit of the two-digit display is being driven
//   SEG_BLANK    : all segments off (active-low)
//   SEG_LUT      : decimal digit 0..9 to active-low segment pattern, seg[6..0] = A..G
//   to_gray()    : 4-bit binary to reflected Gray code
package gray_disp_pkg;

  typedef enum logic {
    UNITS = 1'b0,
    TENS  = 1'b1
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
    7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
  };

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/binary_to_gray_display_sync_debounce.sv
// Two-stage synchronizer plus whole-word debouncer.
//   clk             : system clock
//   rst             : synchronous active-high reset
//   din_i           : raw asynchronous input word (may bounce)
//   accepted_next_o : accepted word as it will be after the coming edge
//   update_o        : high in the cycle whose edge accepts a new word
// A word is accepted once the synchronized value has matched the candidate
// for DEBOUNCE_CYCLES counted cycles and differs from the current accepted word.
module sync_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] accepted_next_o,
  output logic             update_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             update;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    update = 1'b0;
    if (sync2_q != cand_q) begin
      // Any disagreement restarts the stability window on the new word.
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Counter saturates here; a word equal to the accepted one stays silent.
      if (cand_q != acc_q) begin
        acc_d  = cand_q;
        update = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign accepted_next_o = acc_d;
  assign update_o        = update;

endmodule

// File: rtl/binary_to_gray_display.sv
// Board block: debounced 4-bit switch value shown as Gray code on active-low
// LEDs and as a decimal number on a two-digit multiplexed 7-segment display.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   bin_in      : raw switch value, asynchronous, may bounce
//   gray        : registered Gray code of the accepted value
//   leds        : active-low LEDs, ~gray
//   code_update : one-cycle pulse when a new value is accepted
//   uni / dec   : units / tens digit transistor enables, active-high
//   seg         : active-low segments, seg[6..0] = A..G
module binary_to_gray_display
  import gray_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned REFRESH_CYCLES  = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bin_in,
  output logic [3:0] gray,
  output logic [3:0] leds,
  output logic       code_update,
  output logic       uni,
  output logic       dec,
  output logic [6:0] seg
);

  localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_CYCLES - 1);

  logic [3:0]       acc_next;
  logic             accept;
  logic [3:0]       digit;

  disp_state_e      state_q, state_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [3:0]       gray_q;
  logic [3:0]       leds_q;
  logic             code_update_q;
  logic             uni_q, uni_d;
  logic             dec_q, dec_d;
  logic [6:0]       seg_q, seg_d;

  sync_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk             (clk),
    .rst             (rst),
    .din_i           (bin_in),
    .accepted_next_o (acc_next),
    .update_o        (accept)
  );

  assign digit = acc_next % 4'd10;

  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    state_d   = state_q;
    if (ref_cnt_q == REF_MAX) begin
      ref_cnt_d = '0;
      state_d   = (state_q == UNITS) ? TENS : UNITS;
    end

    // Digit content uses the value accepted on this same edge, so a new
    // value appears immediately inside the phase being shown.
    uni_d = 1'b0;
    dec_d = 1'b0;
    seg_d = SEG_BLANK;
    if (state_q == UNITS) begin
      uni_d = 1'b1;
      seg_d = SEG_LUT[digit];
    end else if (acc_next >= 4'd10) begin
      dec_d = 1'b1;
      seg_d = SEG_LUT[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= UNITS;
      ref_cnt_q     <= '0;
      gray_q        <= 4'h0;
      leds_q        <= 4'hF;
      code_update_q <= 1'b0;
      uni_q         <= 1'b0;
      dec_q         <= 1'b0;
      seg_q         <= SEG_BLANK;
    end else begin
      state_q       <= state_d;
      ref_cnt_q     <= ref_cnt_d;
      gray_q        <= to_gray(acc_next);
      leds_q        <= ~to_gray(acc_next);
      code_update_q <= accept;
      uni_q         <= uni_d;
      dec_q         <= dec_d;
      seg_q         <= seg_d;
    end
  end

  assign gray        = gray_q;
  assign leds        = leds_q;
  assign code_update = code_update_q;
  assign uni         = uni_q;
  assign dec         = dec_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_binary_to_gray_display.sv
module tb_binary_to_gray_display;

  localparam int DB = 4;
  localparam int RF = 3;

  logic       clk;
  logic       rst;
  logic [3:0] bin_in;
  logic [3:0] gray;
  logic [3:0] leds;
  logic       code_update;
  logic       uni;
  logic       dec;
  logic [6:0] seg;

  binary_to_gray_display #(
    .DEBOUNCE_CYCLES (DB),
    .REFRESH_CYCLES  (RF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bin_in      (bin_in),
    .gray        (gray),
    .leds        (leds),
    .code_update (code_update),
    .uni         (uni),
    .dec         (dec),
    .seg         (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the synchronized stream is the switch value two edges
  // late; a value is taken once it has been seen on DB+1 consecutive edges
  // (the candidate-load edge plus DB counted edges) and differs from the
  // current value. The display phase is a pure function of edges since reset.
  logic [6:0]  pat [0:9] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                             7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
  logic [3:0]  m_dly0, m_dly1, m_acc;
  logic [3:0]  m_hist [$];
  int          m_n;
  logic        m_upd;
  logic [17:0] exp_vec;

  localparam logic [17:0] RESET_VEC = {4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 7'h7F};

  function automatic logic [17:0] dut_vec();
    return {gray, leds, code_update, uni, dec, seg};
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] b);
    logic [3:0] s;
    logic       all_eq;
    logic       units;
    logic [3:0] g;
    logic [6:0] sg;
    if (r) begin
      m_dly0 = 4'd0; m_dly1 = 4'd0; m_acc = 4'd0;
      m_hist = {};
      m_hist.push_back(4'd0);
      m_n = 0; m_upd = 1'b0;
      exp_vec = RESET_VEC;
    end else begin
      s = m_dly1;
      m_dly1 = m_dly0;
      m_dly0 = b;
      m_hist.push_back(s);
      if (m_hist.size() > DB + 1) void'(m_hist.pop_front());
      all_eq = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != s) all_eq = 1'b0;
      m_upd = (m_hist.size() == DB + 1) && all_eq && (s != m_acc);
      if (m_upd) m_acc = s;
      m_n++;
      units = (((m_n - 1) / RF) % 2) == 0;
      g = m_acc ^ (m_acc / 2);
      if (units) sg = pat[m_acc % 10];
      else if (m_acc >= 10) sg = pat[1];
      else sg = 7'h7F;
      exp_vec = {g, ~g, m_upd, units, (!units && m_acc >= 10), sg};
    end
  endtask

  task automatic step(input logic r, input logic [3:0] b);
    rst = r;
    bin_in = b;
    @(posedge clk);
    #1;
    model_edge(r, b);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'hA);
      checks++;
      if (dut_vec() !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, dut_vec(), RESET_VEC);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 4'h0);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
      checks++;
      if ({uni, dec, seg} !== ((i <= 3) ? {1'b1, 1'b0, 7'h01} : {1'b0, 1'b0, 7'h7F})) begin
        errors++;
        $display("FAIL reset_phase cyc=%0d got=%b_%b_%h", i, uni, dec, seg);
      end
    end
  endtask

  task automatic test_acceptance();
    int pulses = 0;
    int pulse_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 4'b1011);
      if (code_update === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL accept_model cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
      if (i == 7) begin
        checks++;
        if ({gray, leds} !== {4'b1110, 4'b0001}) begin
          errors++;
          $display("FAIL accept_value got=%b/%b want=1110/0001", gray, leds);
        end
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 7) begin
      errors++;
      $display("FAIL accept_pulse count=%0d at=%0d want count=1 at=7", pulses, pulse_at);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, (i < 2) ? 4'hF : 4'b1011);
      if (code_update === 1'b1) pulses++;
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
      checks++;
      if ({gray, leds} !== {4'b1110, 4'b0001}) begin
        errors++;
        $display("FAIL glitch_hold cyc=%0d got=%b/%b want=1110/0001", i, gray, leds);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL glitch_pulse got=%0d want=0", pulses);
    end
  endtask

  task automatic test_display_12();
    int units_cyc = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 4'd12);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'd12);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL disp12_model cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
      if (uni === 1'b1) units_cyc++;
      checks++;
      if ({uni, dec, seg} !== {1'b1, 1'b0, 7'h12} && {uni, dec, seg} !== {1'b0, 1'b1, 7'h4F}) begin
        errors++;
        $display("FAIL disp12_digit cyc=%0d got=%b_%b_%h", i, uni, dec, seg);
      end
    end
    checks++;
    if (units_cyc != 6) begin
      errors++;
      $display("FAIL disp12_alternate units=%0d want=6", units_cyc);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] b;
    for (int v = 0; v < 16; v++) begin
      b = 4'(v);
      for (int i = 0; i < 10; i++) begin
        step(1'b0, b);
        checks++;
        if (dut_vec() !== exp_vec) begin
          errors++;
          $display("FAIL sweep_model v=%0d cyc=%0d got=%h want=%h", v, i, dut_vec(), exp_vec);
        end
      end
      checks++;
      if (gray !== (b ^ (b >> 1))) begin
        errors++;
        $display("FAIL sweep_gray v=%0d got=%b want=%b", v, gray, b ^ (b >> 1));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    int hold;
    int n = 0;
    while (n < 200) begin
      b = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) begin
        step(1'b0, b);
        n++;
        checks++;
        if (dut_vec() !== exp_vec) begin
          errors++;
          $display("FAIL random_model n=%0d in=%h got=%h want=%h", n, b, dut_vec(), exp_vec);
        end
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    int first_at = -1;
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'd0);
    // Edges 1-2 fill the synchronizer, 3 loads the candidate, 4-5 count.
    for (int i = 1; i <= 5; i++) begin
      step((i == 5), 4'd9);
      checks++;
      if (gray !== 4'd0) begin
        errors++;
        $display("FAIL middeb_pre cyc=%0d got=%b want=0000", i, gray);
      end
    end
    step(1'b1, 4'd9);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 4'd9);
      checks++;
      if (dut_vec() !== exp_vec) begin
        errors++;
        $display("FAIL middeb_model cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec);
      end
      if (first_at < 0 && gray === 4'b1101) first_at = i;
    end
    // Acceptance six edges after the first unreset edge.
    checks++;
    if (first_at != 7) begin
      errors++;
      $display("FAIL middeb_latency got=%0d want=7", first_at);
    end
  endtask

  initial begin
    rst = 1'b1;
    bin_in = 4'h0;
    m_hist = {};
    model_edge(1'b1, 4'h0);
    test_reset();
    test_acceptance();
    test_glitch();
    test_display_12();
    test_sweep();
    test_random();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
